seq_pattern_gen: RTL and testbench

- Programmable successor to the fixed 8-entry byte sequence generator.
- Holds a DEPTH x DATA_W pattern memory that is written through a load port while idle. Plays the pattern out one entry per enabled clock, in loop or one-shot mode, over a run-time selectable length.
- Sits beside the existing generators and drives test/stimulus buses in the design.

---
 rtl/seq_pattern_gen.sv | 177 +++++++++++++++++
 tb/tb_seq_pattern_gen.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_pattern_gen.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// seq_pattern_gen
//   Programmable pattern sequencer. A DEPTH x DATA_W pattern memory is written
//   through the load port while idle. After a start pulse, one entry is played
//   out per enabled clock. Playback runs in loop or one-shot mode over entries
//   0..last_idx.
//
//   Optional feature: define SEQ_PINGPONG_EN to make mode 2 walk the pattern
//   up and down (ping-pong). With the macro undefined, mode 2 plays as loop
//   and no ping-pong logic is built.
//
// Ports:
//   clock      in   system clock, rising edge
//   reset      in   synchronous active-high reset
//   enable     in   step qualifier while running (low = hold)
//   start      in   pulse, begins playback at index 0 when idle
//   stop       in   pulse, aborts playback (wins over a coincident step)
//   mode       in   0 loop, 1 one-shot, 2 ping-pong (optional), 3 loop
//   last_idx   in   index of the final active entry (clamped to DEPTH-1)
//   load_we    in   pattern write strobe (accepted only when idle)
//   load_addr  in   pattern write address
//   load_data  in   pattern write data
//   data       out  registered pattern output
//   valid      out  one cycle per emitted entry
//   busy       out  high while running
//   wrap       out  pulse with the entry emitted as the sequence returns to 0
//   done       out  pulse with the last one-shot entry
//   load_err   out  pulse the cycle after a write attempted while busy
// -----------------------------------------------------------------------------
module seq_pattern_gen #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              start,
  input  logic              stop,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] last_idx,
  input  logic              load_we,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  output logic              busy,
  output logic              wrap,
  output logic              done,
  output logic              load_err
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [1:0] M_ONESHOT = 2'd1;
`ifdef SEQ_PINGPONG_EN
  localparam logic [1:0] M_PINGPONG = 2'd2;
`endif

  localparam logic [ADDR_W-1:0] MAX_IDX = ADDR_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [0:0]        state;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] run_last;
  logic [1:0]        run_mode;
`ifdef SEQ_PINGPONG_EN
  logic              going_down;
  logic              first_step;
`endif

  assign busy = (state == S_RUN);

  // NOTE: the pattern memory has no reset; clearing every entry would turn a
  // plain RAM into a bank of resettable flops, and its contents are always
  // written before use. Writes are only accepted while idle, so a run in
  // progress always sees a stable pattern.
  always_ff @(posedge clock) begin
    if (load_we && state == S_IDLE)
      mem[load_addr] <= load_data;
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the values from before the edge, regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_IDLE;
      idx      <= '0;
      run_last <= '0;
      run_mode <= '0;
      data     <= '0;
      valid    <= 1'b0;
      wrap     <= 1'b0;
      done     <= 1'b0;
      load_err <= 1'b0;
`ifdef SEQ_PINGPONG_EN
      going_down <= 1'b0;
      first_step <= 1'b0;
`endif
    end else begin
      valid    <= 1'b0;
      wrap     <= 1'b0;
      done     <= 1'b0;
      load_err <= load_we && (state == S_RUN);

      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_RUN;
            idx      <= '0;
            run_mode <= mode;
            run_last <= (last_idx > MAX_IDX) ? MAX_IDX : last_idx;
`ifdef SEQ_PINGPONG_EN
            going_down <= 1'b0;
            first_step <= 1'b1;
`endif
          end
        end

        S_RUN: begin
          if (stop) begin
            state <= S_IDLE;
          end else if (enable) begin
            data  <= mem[idx];
            valid <= 1'b1;
`ifdef SEQ_PINGPONG_EN
            first_step <= 1'b0;
`endif
            if (run_mode == M_ONESHOT) begin
              if (idx == run_last) begin
                done  <= 1'b1;
                state <= S_IDLE;
                idx   <= '0;
              end else begin
                idx <= idx + 1'b1;
              end
            end
`ifdef SEQ_PINGPONG_EN
            else if (run_mode == M_PINGPONG) begin
              // The very first entry 0 of a run is not a return to 0.
              wrap <= (idx == '0) && !first_step;
              if (going_down) begin
                idx <= idx - 1'b1;
                if (idx == ADDR_W'(1))
                  going_down <= 1'b0;
              end else if (idx == run_last) begin
                // Turn around without repeating the top entry. With
                // run_last = 1 the next entry is already the bottom one.
                if (run_last != '0) begin
                  idx        <= run_last - 1'b1;
                  going_down <= (run_last != ADDR_W'(1));
                end
              end else begin
                idx <= idx + 1'b1;
              end
            end
`endif
            else begin
              // Loop (mode 0, reserved mode 3, and mode 2 without ping-pong).
              if (idx == run_last) begin
                idx  <= '0;
                wrap <= 1'b1;
              end else begin
                idx <= idx + 1'b1;
              end
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_pattern_gen.sv
`timescale 1ns/1ps
module tb_seq_pattern_gen;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;

  logic              clock;
  logic              reset;
  logic              enable;
  logic              start;
  logic              stop;
  logic [1:0]        mode;
  logic [ADDR_W-1:0] last_idx;
  logic              load_we;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              busy;
  logic              wrap;
  logic              done;
  logic              load_err;

  seq_pattern_gen #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clock    (clock),
    .reset    (reset),
    .enable   (enable),
    .start    (start),
    .stop     (stop),
    .mode     (mode),
    .last_idx (last_idx),
    .load_we  (load_we),
    .load_addr(load_addr),
    .load_data(load_data),
    .data     (data),
    .valid    (valid),
    .busy     (busy),
    .wrap     (wrap),
    .done     (done),
    .load_err (load_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;
  bit checking = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: tracks how many entries of the current run were emitted
  // (step count k) and derives the pattern position arithmetically from k.
  // ---------------------------------------------------------------------------
  bit [7:0] m_mem [DEPTH];
  bit       m_run;
  int       m_k;
  int       m_L;
  bit [1:0] m_mode;
  bit [7:0] exp_data;
  bit       exp_valid, exp_wrap, exp_done, exp_err;

  function automatic int clamp_last(input int v);
    return (v > DEPTH - 1) ? DEPTH - 1 : v;
  endfunction

  function automatic bit is_pp(input bit [1:0] m);
`ifdef SEQ_PINGPONG_EN
    return m == 2'd2;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int pos_of(input int k, input int L, input bit pp);
    int p;
    if (pp) begin
      if (L == 0) return 0;
      p = k % (2 * L);
      return (p <= L) ? p : 2 * L - p;
    end
    return k % (L + 1);
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      m_run     <= 1'b0;
      m_k       <= 0;
      exp_data  <= '0;
      exp_valid <= 1'b0;
      exp_wrap  <= 1'b0;
      exp_done  <= 1'b0;
      exp_err   <= 1'b0;
    end else begin
      exp_valid <= 1'b0;
      exp_wrap  <= 1'b0;
      exp_done  <= 1'b0;
      exp_err   <= load_we && m_run;
      if (!m_run) begin
        if (load_we) m_mem[load_addr] <= load_data;
        if (start) begin
          m_run  <= 1'b1;
          m_k    <= 0;
          m_L    <= clamp_last(int'(last_idx));
          m_mode <= mode;
        end
      end else if (stop) begin
        m_run <= 1'b0;
      end else if (enable) begin
        exp_data  <= m_mem[pos_of(m_k, m_L, is_pp(m_mode))];
        exp_valid <= 1'b1;
        if (m_mode == 2'd1) begin
          if (m_k == m_L) begin
            exp_done <= 1'b1;
            m_run    <= 1'b0;
          end else begin
            m_k <= m_k + 1;
          end
        end else if (is_pp(m_mode)) begin
          exp_wrap <= (pos_of(m_k, m_L, 1'b1) == 0) && (m_k > 0);
          m_k      <= m_k + 1;
        end else begin
          exp_wrap <= (pos_of(m_k, m_L, 1'b0) == m_L);
          m_k      <= m_k + 1;
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    if (checking) begin
      check("data",     32'(data),     32'(exp_data));
      check("valid",    32'(valid),    32'(exp_valid));
      check("busy",     32'(busy),     32'(m_run));
      check("wrap",     32'(wrap),     32'(exp_wrap));
      check("done",     32'(done),     32'(exp_done));
      check("load_err", 32'(load_err), 32'(exp_err));
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic write_mem(input logic [ADDR_W-1:0] a, input logic [7:0] d);
    load_we   = 1'b1;
    load_addr = a;
    load_data = d;
    tick();
    load_we   = 1'b0;
  endtask

  task automatic start_run(input logic [1:0] m, input logic [ADDR_W-1:0] l);
    mode     = m;
    last_idx = l;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  task automatic stop_run();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  // Waits (bounded) for the next emitted entry and pins its value and wrap.
  task automatic expect_emit(input string name, input logic [7:0] d, input logic w);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clock);
      if (valid === 1'b1) begin
        seen = 1'b1;
        check({name, "_data"}, 32'(data), 32'(d));
        check({name, "_wrap"}, 32'(wrap), 32'(w));
      end
    end
    if (!seen) check({name, "_timeout"}, 32'(0), 32'(1));
  endtask

  logic [7:0] legacy [DEPTH];
  logic [7:0] pp_seq [10];
  logic       pp_wrp [10];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    legacy = '{8'hAF, 8'hBC, 8'hE2, 8'h78, 8'hFF, 8'hE2, 8'h0B, 8'h8D};
    reset = 1'b1; enable = 1'b0; start = 1'b0; stop = 1'b0; mode = 2'd0;
    last_idx = '0; load_we = 1'b0; load_addr = '0; load_data = '0;
    tick();
    tick();
    reset = 1'b0;
    checking = 1'b1;
    @(negedge clock);
    check("rst_data",  32'(data),  32'h0);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_busy",  32'(busy),  32'h0);

    // Legacy pattern, loop over all 8 entries.
    for (int i = 0; i < DEPTH; i++) write_mem(ADDR_W'(i), legacy[i]);
    enable = 1'b1;
    start_run(2'd0, 3'd7);
    for (int i = 0; i < 16; i++)
      expect_emit("loop", legacy[i % DEPTH], (i % DEPTH) == DEPTH - 1);
    check("loop_busy", 32'(busy), 32'h1);

    // Stop with enable high: no step, data holds the last entry.
    stop_run();
    @(negedge clock);
    check("stop_valid", 32'(valid), 32'h0);
    check("stop_busy",  32'(busy),  32'h0);
    check("stop_data",  32'(data),  32'h8D);
    start_run(2'd0, 3'd7);
    expect_emit("restart0", 8'hAF, 1'b0);
    expect_emit("restart1", 8'hBC, 1'b0);
    stop_run();

    // One-shot over 0..2 with enable toggled 1,0,1,1.
    enable = 1'b0;
    start_run(2'd1, 3'd2);
    enable = 1'b1; tick(); @(negedge clock);
    check("os0_data", 32'(data), 32'hAF);
    check("os0_valid", 32'(valid), 32'h1);
    enable = 1'b0; tick(); @(negedge clock);
    check("os_hold_valid", 32'(valid), 32'h0);
    enable = 1'b1; tick(); @(negedge clock);
    check("os1_data", 32'(data), 32'hBC);
    tick(); @(negedge clock);
    check("os2_data", 32'(data), 32'hE2);
    check("os2_done", 32'(done), 32'h1);
    check("os2_busy", 32'(busy), 32'h0);
    enable = 1'b0; tick(); @(negedge clock);
    check("os_after_data", 32'(data), 32'hE2);
    check("os_after_done", 32'(done), 32'h0);

    // Write while busy is dropped and flagged; write while idle takes effect.
    enable = 1'b1;
    start_run(2'd0, 3'd7);
    write_mem(3'd3, 8'h55);
    @(negedge clock);
    check("err_pulse", 32'(load_err), 32'h1);
    @(negedge clock);
    check("err_clear", 32'(load_err), 32'h0);
    stop_run();
    start_run(2'd0, 3'd7);
    expect_emit("busy_wr0", 8'hAF, 1'b0);
    expect_emit("busy_wr1", 8'hBC, 1'b0);
    expect_emit("busy_wr2", 8'hE2, 1'b0);
    expect_emit("busy_wr3", 8'h78, 1'b0);
    stop_run();
    write_mem(3'd3, 8'h55);
    start_run(2'd0, 3'd7);
    expect_emit("idle_wr0", 8'hAF, 1'b0);
    expect_emit("idle_wr1", 8'hBC, 1'b0);
    expect_emit("idle_wr2", 8'hE2, 1'b0);
    expect_emit("idle_wr3", 8'h55, 1'b0);
    stop_run();
    write_mem(3'd3, 8'h78);

    // Largest last_idx (15 truncates to the 3-bit port) plays all entries.
    start_run(2'd0, '1);
    for (int i = 0; i < DEPTH; i++)
      expect_emit("clamp", legacy[i], i == DEPTH - 1);
    // Reset mid-run.
    reset = 1'b1; tick(); reset = 1'b0;
    @(negedge clock);
    check("mid_rst_data",  32'(data),  32'h0);
    check("mid_rst_valid", 32'(valid), 32'h0);
    check("mid_rst_busy",  32'(busy),  32'h0);
    check("mid_rst_done",  32'(done),  32'h0);

    // Mode 2 with last_idx = 3.
`ifdef SEQ_PINGPONG_EN
    pp_seq = '{8'hAF, 8'hBC, 8'hE2, 8'h78, 8'hE2, 8'hBC, 8'hAF, 8'hBC, 8'hE2, 8'h78};
    pp_wrp = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
`else
    pp_seq = '{8'hAF, 8'hBC, 8'hE2, 8'h78, 8'hAF, 8'hBC, 8'hE2, 8'h78, 8'hAF, 8'hBC};
    pp_wrp = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
`endif
    start_run(2'd2, 3'd3);
    for (int i = 0; i < 10; i++) expect_emit("mode2", pp_seq[i], pp_wrp[i]);
    stop_run();

    // Randomized phase, checked every cycle against the model.
    for (int i = 0; i < 600; i++) begin
      reset     = ($urandom_range(0, 99) == 0);
      start     = ($urandom_range(0, 7) == 0);
      stop      = ($urandom_range(0, 39) == 0);
      enable    = ($urandom_range(0, 3) != 0);
      mode      = 2'($urandom_range(0, 3));
      last_idx  = ADDR_W'($urandom_range(0, DEPTH - 1));
      load_we   = ($urandom_range(0, 3) == 0);
      load_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
      load_data = 8'($urandom);
      tick();
    end
    reset = 1'b0; start = 1'b0; stop = 1'b0; load_we = 1'b0;
    tick();
    @(negedge clock);
    checking = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
